// File: rtl/param_mux_reg.sv
// param_mux_reg: N-to-1 channel select (direct or auto-scan) into one registered valid/ready output stage
module param_mux_reg #(
  parameter int NUM_INPUTS = 31,
  parameter int WIDTH = 2,
  parameter int SEL_W = 5,
  parameter int ERR_CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS*WIDTH-1:0] inp,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out,
  output logic [SEL_W-1:0]            out_sel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        sel_err,
  output logic [ERR_CNT_W-1:0]        err_count
);
  logic [WIDTH-1:0] ch [2**SEL_W];
  logic [SEL_W-1:0] ptr, idx, ptr_next;
  logic cap, in_range;
  for (genvar k = 0; k < 2**SEL_W; k++) begin : g_ch
    if (k < NUM_INPUTS) begin : g_in
      assign ch[k] = inp[k*WIDTH +: WIDTH];
    end else begin : g_zero
      assign ch[k] = '0;
    end
  end
  assign in_ready = !out_valid || out_ready;
  assign cap = in_valid && in_ready;
  assign idx = mode ? ptr : sel;
  assign in_range = 32'(idx) < NUM_INPUTS;
  // pointer wraps at the last real channel so scan never produces a bad index
  assign ptr_next = (ptr == SEL_W'(NUM_INPUTS - 1)) ? '0 : ptr + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      out_sel <= '0;
      out_valid <= 1'b0;
      sel_err <= 1'b0;
      err_count <= '0;
      ptr <= '0;
    end else if (cap) begin
      out <= in_range ? ch[idx] : '0;
      out_sel <= idx;
      sel_err <= !in_range;
      out_valid <= 1'b1;
      if (!in_range && !(&err_count)) err_count <= err_count + 1'b1;
      if (mode) ptr <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_param_mux_reg.sv
// tb_param_mux_reg: scoreboard bench for param_mux_reg using its default parameters
module tb_param_mux_reg;
  localparam int N = 31;
  localparam int W = 2;
  typedef struct {
    logic [W-1:0] data;
    logic [4:0]   sel;
    logic         err;
  } beat_t;
  logic clk = 0, reset = 1, mode = 0, in_valid = 0, out_ready = 0;
  logic [N*W-1:0] inp;
  logic [4:0] sel = 0;
  logic in_ready, out_valid, sel_err;
  logic [W-1:0] out;
  logic [4:0] out_sel;
  logic [7:0] err_count;
  beat_t q[$];
  beat_t e;
  logic m_valid = 0;
  int m_ptr = 0, m_err = 0;
  int vectors = 0, miss = 0;
  param_mux_reg dut (
    .clk(clk), .reset(reset), .inp(inp), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic drive_edge();
    int idx;
    beat_t b;
    if (reset) begin
      q.delete();
      m_valid = 0;
      m_ptr = 0;
      m_err = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      idx = mode ? m_ptr : int'(sel);
      b.sel = 5'(idx);
      b.err = idx >= N;
      b.data = '0;
      if (!b.err) b.data = inp[idx*W +: W];
      q.push_back(b);
      m_valid = 1;
      if (b.err && m_err != 255) m_err++;
      if (mode) m_ptr = (m_ptr == N - 1) ? 0 : m_ptr + 1;
    end else if (out_ready) m_valid = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1;
    drive_edge();
    vectors++;
    if ({out_valid, out, out_sel, sel_err, err_count, in_ready} !== {1'b0, 2'd0, 5'd0, 1'b0, 8'd0, 1'b1}) begin
      miss++;
      $display("FAIL reset: got v=%b out=%0d sel=%0d err=%b cnt=%0d rdy=%b, want 0 0 0 0 0 1", out_valid, out, out_sel, sel_err, err_count, in_ready);
    end
    reset = 0;
  endtask
  task automatic test_direct();
    int sels[4] = '{0, 1, 13, 30};
    mode = 0; out_ready = 1; in_valid = 1;
    foreach (sels[i]) begin
      sel = 5'(sels[i]);
      drive_edge();
      e = q.pop_front();
      vectors++;
      if ({out_valid, out, out_sel, sel_err, err_count} !== {1'b1, e.data, e.sel, e.err, 8'(m_err)}) begin
        miss++;
        $display("FAIL direct sel=%0d: got v=%b out=%0d osel=%0d err=%b cnt=%0d, want 1 %0d %0d %b %0d", sels[i], out_valid, out, out_sel, sel_err, err_count, e.data, e.sel, e.err, m_err);
      end
    end
    in_valid = 0;
    drive_edge();
    vectors++;
    if ({out_valid, out} !== {1'b0, 2'd2}) begin
      miss++;
      $display("FAIL drain: got v=%b out=%0d, want 0 2", out_valid, out);
    end
  endtask
  task automatic test_out_of_range();
    mode = 0; out_ready = 1; in_valid = 1; sel = 31;
    drive_edge();
    e = q.pop_front();
    vectors++;
    if ({out_valid, out, out_sel, sel_err, err_count} !== {1'b1, 2'd0, 5'd31, 1'b1, 8'd1}) begin
      miss++;
      $display("FAIL oor_first: got v=%b out=%0d osel=%0d err=%b cnt=%0d, want 1 0 31 1 1", out_valid, out, out_sel, sel_err, err_count);
    end
    for (int i = 0; i < 300; i++) begin
      drive_edge();
      e = q.pop_front();
      vectors++;
      if ({sel_err, err_count} !== {1'b1, 8'(m_err)}) begin
        miss++;
        $display("FAIL oor_count[%0d]: got err=%b cnt=%0d, want 1 %0d", i, sel_err, err_count, m_err);
      end
    end
    vectors++;
    if (err_count !== 8'd255) begin
      miss++;
      $display("FAIL oor_saturate: got %0d, want 255", err_count);
    end
    in_valid = 0;
    drive_edge();
  endtask
  task automatic test_backpressure();
    mode = 0; out_ready = 1; in_valid = 1; sel = 5;
    inp[5*W +: W] = 2'd3;
    drive_edge();
    e = q.pop_front();
    vectors++;
    if ({out_valid, out, out_sel} !== {1'b1, 2'd3, 5'd5}) begin
      miss++;
      $display("FAIL bp_capture: got v=%b out=%0d osel=%0d, want 1 3 5", out_valid, out, out_sel);
    end
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      sel = 5'($urandom_range(0, 31));
      mode = 1'($urandom_range(0, 1));
      inp[5*W +: W] = 2'($urandom_range(0, 2));
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
        miss++;
        $display("FAIL bp_ready[%0d]: got %b, want 0", i, in_ready);
      end
      drive_edge();
      vectors++;
      if ({out_valid, out, out_sel, sel_err} !== {1'b1, 2'd3, 5'd5, 1'b0}) begin
        miss++;
        $display("FAIL bp_hold[%0d]: got v=%b out=%0d osel=%0d err=%b, want 1 3 5 0", i, out_valid, out, out_sel, sel_err);
      end
    end
    mode = 0; out_ready = 1; sel = 6;
    inp[5*W +: W] = 2'd1;
    drive_edge();
    e = q.pop_front();
    vectors++;
    if ({out_valid, out, out_sel} !== {1'b1, 2'd2, 5'd6}) begin
      miss++;
      $display("FAIL bp_release: got v=%b out=%0d osel=%0d, want 1 2 6", out_valid, out, out_sel);
    end
  endtask
  task automatic test_scan();
    mode = 1; out_ready = 1; in_valid = 1;
    for (int i = 0; i < 33; i++) begin
      drive_edge();
      e = q.pop_front();
      vectors++;
      if ({out_valid, out, out_sel, sel_err} !== {1'b1, 2'((i % N) % 4), 5'(i % N), 1'b0} || e.sel !== 5'(i % N)) begin
        miss++;
        $display("FAIL scan[%0d]: got v=%b out=%0d osel=%0d err=%b, want 1 %0d %0d 0", i, out_valid, out, out_sel, sel_err, (i % N) % 4, i % N);
      end
    end
  endtask
  task automatic test_mode_mix();
    reset = 1;
    drive_edge();
    reset = 0;
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      mode = (i < 3 || i == 5);
      sel = 20;
      drive_edge();
      e = q.pop_front();
      vectors++;
      if ({out_valid, out, out_sel, sel_err} !== {1'b1, e.data, e.sel, e.err}) begin
        miss++;
        $display("FAIL mix[%0d]: got v=%b out=%0d osel=%0d err=%b, want 1 %0d %0d %b", i, out_valid, out, out_sel, sel_err, e.data, e.sel, e.err);
      end
    end
    vectors++;
    if (out_sel !== 5'd3) begin
      miss++;
      $display("FAIL mix_resume: got osel=%0d, want 3", out_sel);
    end
  endtask
  task automatic test_reset_mid();
    mode = 0; sel = 31; out_ready = 1; in_valid = 1;
    drive_edge();
    e = q.pop_front();
    mode = 1;
    for (int i = 0; i < 3; i++) begin
      drive_edge();
      e = q.pop_front();
    end
    vectors++;
    if ({out_sel, err_count} !== {5'd6, 8'd1}) begin
      miss++;
      $display("FAIL mid_setup: got osel=%0d cnt=%0d, want 6 1", out_sel, err_count);
    end
    out_ready = 0; in_valid = 0;
    drive_edge();
    reset = 1; in_valid = 1;
    drive_edge();
    vectors++;
    if ({out_valid, out, err_count} !== {1'b0, 2'd0, 8'd0}) begin
      miss++;
      $display("FAIL mid_reset: got v=%b out=%0d cnt=%0d, want 0 0 0", out_valid, out, err_count);
    end
    reset = 0; mode = 1; out_ready = 1;
    drive_edge();
    e = q.pop_front();
    vectors++;
    if ({out_valid, out_sel, out} !== {1'b1, 5'd0, 2'd0}) begin
      miss++;
      $display("FAIL mid_restart: got v=%b osel=%0d out=%0d, want 1 0 0", out_valid, out_sel, out);
    end
  endtask
  initial begin
    for (int k = 0; k < N; k++) inp[k*W +: W] = W'(k % 4);
    test_reset();
    test_direct();
    test_out_of_range();
    test_backpressure();
    test_scan();
    test_mode_mix();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
